// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with mid-bit sampling, valid/read handshake,
// framing and overrun flags. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       rx_read,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decisions are taken one clock after the nominal point so the +1 sample is available.
  localparam logic [15:0] START_AT = 16'(CLKS_PER_BIT / 2 + 1);
`else
  localparam logic [15:0] START_AT = 16'(CLKS_PER_BIT / 2);
`endif

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        load, ferr;
  logic        sync1, rxs, rxs_d;
  logic        smp;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      sync1  <= rx_pin;
      rxs    <= sync1;
      rxs_d  <= rxs;
      rxs_d2 <= rxs_d;
    end
  end

  assign smp = (rxs_d2 & rxs_d) | (rxs_d2 & rxs) | (rxs_d & rxs);
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign smp = rxs;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    shift_n = shift;
    load    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        // Counter sits at zero so the edge-detect cycle itself is count 0.
        cnt_n = '0;
        if (rxs_d && !rxs) begin
          state_n = START;
          cnt_n   = 16'd1;
        end
      end
      START: begin
        if (cnt == START_AT) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = smp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_n[idx] = smp;
          cnt_n        = '0;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (smp) begin
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= ferr;
      if (load) begin
        rx_byte    <= shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_read ? 1'b0 : (rx_overrun | rx_valid);
      end else if (rx_read && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16; honours UART_RX_MAJORITY_EN.
module tb_uart_rx;

  localparam int unsigned C = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 156;
  localparam logic [7:0] GLITCH_BYTE = 8'h00;
`else
  localparam int LAT = 155;
  localparam logic [7:0] GLITCH_BYTE = 8'h08;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, frame_err, rx_busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .rx_pin(rx_pin),
    .rx_read(rx_read),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_overrun(rx_overrun),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_cnt++;

  // Start bit is driven on the first negedge; each bit lasts C negedges.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk) rx_pin = 1'b0;
    repeat (C - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx_pin = b[i];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk) rx_pin = stop;
    repeat (C - 1) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk) rx_read = 1'b1;
    @(negedge clk) rx_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid got %b want 0", rx_valid); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid got %b want 1", rx_valid); end
      end
    join
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("FAIL basic_byte: got %h want 55", rx_byte); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", rx_overrun); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL basic_frame_err: pulses %0d want 0", fe_cnt - fe0); end
    pulse_read();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_read: valid got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int   fe0;
    logic busy_seen;
    fe0 = fe_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rx_pin = (i >= 5);
      busy_seen = busy_seen | rx_busy;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", busy_seen); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %b want 0", rx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_frame_err: pulses %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (50) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: pulses %0d want 1", fe_cnt - fe0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("FAIL ferr_byte_kept: got %h want 55", rx_byte); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b want 1", rx_busy); end
    @(negedge clk) rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", rx_busy); end
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL ferr_next_byte: got %h want 3c", rx_byte); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_next_valid: got %b want 1", rx_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk) rx_pin = 1'b0;
    repeat (C - 1) @(negedge clk);
    @(negedge clk) rx_pin = 1'b1;
    repeat (72) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", rx_busy); end
    rst = 1'b0;
    #1;
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h want 00", rx_byte); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", rx_overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
    @(negedge clk) rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL rstmid_next_byte: got %h want 81", rx_byte); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next_valid: got %b want 1", rx_valid); end
    pulse_read();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== 8'h22) begin errors++; $display("FAIL b2b_byte: got %h want 22", rx_byte); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", rx_overrun); end
    pulse_read();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_read_valid: got %b want 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_read_overrun: got %b want 0", rx_overrun); end
  endtask

  task automatic test_read_at_completion();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk) rx_read = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== 8'h33) begin errors++; $display("FAIL simul_byte: got %h want 33", rx_byte); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b want 0", rx_overrun); end
    pulse_read();
  endtask

  task automatic test_sample_glitch();
    // One-clock high pulse on the bit-3 sample point of an all-zero byte.
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      rx_pin = (i == 72) || (i >= 144);
    end
    repeat (4) @(negedge clk);
    checks++; if (rx_byte !== GLITCH_BYTE) begin errors++; $display("FAIL sample_glitch_byte: got %h want %h", rx_byte, GLITCH_BYTE); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL sample_glitch_valid: got %b want 1", rx_valid); end
    pulse_read();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_read_at_completion();
    test_sample_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
